// File: rtl/quadrature_decoder.sv
// quadrature_decoder: samples raw A/B/I encoder pins on the system clock,
// synchronises and glitch-filters them, decodes 4x quadrature into a signed
// position with optional CPR wrap, supports index homing and counts illegal
// transitions.

module quadrature_decoder #(
    parameter int WIDTH      = 32,
    parameter int FILTER_LEN = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             A,
    input  logic             B,
    input  logic             I,
    input  logic [WIDTH-1:0] DataBus,
    input  logic             LoadCPR,
    input  logic             LoadPosition,
    input  logic [1:0]       IndexMode,
    input  logic             ArmIndex,
    input  logic             ClearError,
    output logic [WIDTH-1:0] Position,
    output logic             Direction,
    output logic             Homed,
    output logic             Error,
    output logic [7:0]       ErrorCount
);

    // Hold-off covers the synchroniser depth, the filter length and one
    // decode stage, so no stale reset value is ever taken for a transition.
    localparam int HOLD_LEN = FILTER_LEN + 3;
    localparam int HOLD_W   = $clog2(HOLD_LEN + 1);
    localparam int CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_LEN);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        IDX_OFF   = 2'd0,
        IDX_EVERY = 2'd1,
        IDX_ONCE  = 2'd2,
        IDX_RSVD  = 2'd3
    } index_mode_t;

    // Values match the modulo-4 distance between successive phase indices.
    typedef enum logic [1:0] {
        MOVE_NONE    = 2'd0,
        MOVE_CW      = 2'd1,
        MOVE_ILLEGAL = 2'd2,
        MOVE_CCW     = 2'd3
    } move_t;

    // Bit order for the pin vectors: [0] = A, [1] = B, [2] = I.
    logic [2:0]        w_pins;
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_filt;
    logic [CNT_W-1:0]  r_filtCnt [3];
    logic [HOLD_W-1:0] r_holdCnt;
    logic              w_holdOff;

    logic [1:0]        r_prevAB;
    logic              r_prevI;
    logic [1:0]        w_curIdx;
    logic [1:0]        w_prevIdx;
    logic [1:0]        w_delta;
    move_t             w_move;
    index_mode_t       w_mode;

    logic              w_stepCw;
    logic              w_stepCcw;
    logic              w_illegal;
    logic              w_indexEvent;
    logic              w_indexZero;

    logic [WIDTH-1:0]  r_cpr;
    logic [WIDTH-1:0]  r_position;
    logic [WIDTH-1:0]  w_cprLast;
    logic [WIDTH-1:0]  w_stepPos;
    logic              r_direction;
    logic              r_homed;
    logic              r_error;
    logic [7:0]        r_errCount;

    assign w_pins    = {I, B, A};
    assign w_holdOff = (r_holdCnt != HOLD_END);
    assign w_mode    = index_mode_t'(IndexMode);
    assign w_cprLast = r_cpr - ONE;

    // Two-flop synchronisers for the asynchronous encoder pins.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
        end
    end

    // Start-up hold-off counter; restarts whenever reset is asserted.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_holdCnt <= '0;
        end else if (w_holdOff) begin
            r_holdCnt <= r_holdCnt + HOLD_W'(1);
        end
    end

    // Glitch filter: a filtered input only changes after FILTER_LEN
    // consecutive samples disagree with it; during hold-off it tracks directly.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_filt <= '0;
            for (int k = 0; k < 3; k++) begin
                r_filtCnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_holdOff) begin
                    r_filt[k]    <= r_sync2[k];
                    r_filtCnt[k] <= '0;
                end else if (r_sync2[k] != r_filt[k]) begin
                    if (r_filtCnt[k] == CNT_LAST) begin
                        r_filt[k]    <= r_sync2[k];
                        r_filtCnt[k] <= '0;
                    end else begin
                        r_filtCnt[k] <= r_filtCnt[k] + CNT_W'(1);
                    end
                end else begin
                    r_filtCnt[k] <= '0;
                end
            end
        end
    end

    // Previous filtered state; seeded from the synchronised pins during
    // hold-off so the first post-hold-off comparison sees no change.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_prevAB <= '0;
            r_prevI  <= 1'b0;
        end else if (w_holdOff) begin
            r_prevAB <= r_sync2[1:0];
            r_prevI  <= r_sync2[2];
        end else begin
            r_prevAB <= r_filt[1:0];
            r_prevI  <= r_filt[2];
        end
    end

    // Quadrature decode: map {A,B} onto a 0..3 phase index (00,10,11,01)
    // so a CW step is +1, CCW is -1 and a double change is 2.
    always_comb begin
        w_curIdx     = {r_filt[1], r_filt[0] ^ r_filt[1]};
        w_prevIdx    = {r_prevAB[1], r_prevAB[0] ^ r_prevAB[1]};
        w_delta      = w_curIdx - w_prevIdx;
        w_move       = move_t'(w_delta);
        w_stepCw     = !w_holdOff && (w_move == MOVE_CW);
        w_stepCcw    = !w_holdOff && (w_move == MOVE_CCW);
        w_illegal    = !w_holdOff && (w_move == MOVE_ILLEGAL);
        w_indexEvent = !w_holdOff && r_filt[2] && !r_prevI;
        w_indexZero  = 1'b0;
        if (w_indexEvent) begin
            case (w_mode)
                IDX_EVERY: w_indexZero = 1'b1;
                IDX_ONCE:  w_indexZero = !r_homed || ArmIndex;
                default:   w_indexZero = 1'b0;
            endcase
        end
    end

    // Candidate position after a quadrature step, with optional CPR wrap.
    always_comb begin
        w_stepPos = r_position;
        if (w_stepCw) begin
            if (r_cpr == '0) begin
                w_stepPos = r_position + ONE;
            end else if ($signed(r_position) >= $signed(w_cprLast)) begin
                w_stepPos = '0;
            end else begin
                w_stepPos = r_position + ONE;
            end
        end else if (w_stepCcw) begin
            if (r_cpr == '0) begin
                w_stepPos = r_position - ONE;
            end else if (r_position[WIDTH-1] || (r_position == '0)) begin
                w_stepPos = w_cprLast;
            end else begin
                w_stepPos = r_position - ONE;
            end
        end
    end

    // Counts-per-revolution register, loaded from the data bus.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cpr <= '0;
        end else if (LoadCPR) begin
            r_cpr <= DataBus;
        end
    end

    // Position: an explicit load beats index zeroing, which beats a step.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_position <= '0;
        end else if (LoadPosition) begin
            r_position <= DataBus;
        end else if (w_indexZero) begin
            r_position <= '0;
        end else begin
            r_position <= w_stepPos;
        end
    end

    // Direction follows every valid step, even one overridden above.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_direction <= 1'b0;
        end else if (w_stepCw) begin
            r_direction <= 1'b1;
        end else if (w_stepCcw) begin
            r_direction <= 1'b0;
        end
    end

    // Homed flag: set by any index zeroing, cleared by re-arming.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_homed <= 1'b0;
        end else if (w_indexZero) begin
            r_homed <= 1'b1;
        end else if (ArmIndex) begin
            r_homed <= 1'b0;
        end
    end

    // Sticky error flag and saturating counter; a same-cycle illegal
    // transition survives a clear and counts as the first new error.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_error    <= 1'b0;
            r_errCount <= '0;
        end else if (w_illegal) begin
            r_error <= 1'b1;
            if (ClearError) begin
                r_errCount <= 8'd1;
            end else if (r_errCount != 8'hFF) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end else if (ClearError) begin
            r_error    <= 1'b0;
            r_errCount <= '0;
        end
    end

    assign Position   = r_position;
    assign Direction  = r_direction;
    assign Homed      = r_homed;
    assign Error      = r_error;
    assign ErrorCount = r_errCount;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed stimulus with hand-computed expectations
// pushed to a scoreboard queue; a monitor pops and compares on request.

module tb_quadrature_decoder;

    localparam int WIDTH      = 32;
    localparam int FILTER_LEN = 3;
    localparam int PHASE      = 10;

    logic             Clock = 1'b0;
    logic             Reset_n;
    logic             A;
    logic             B;
    logic             I;
    logic [WIDTH-1:0] DataBus;
    logic             LoadCPR;
    logic             LoadPosition;
    logic [1:0]       IndexMode;
    logic             ArmIndex;
    logic             ClearError;
    logic [WIDTH-1:0] Position;
    logic             Direction;
    logic             Homed;
    logic             Error;
    logic [7:0]       ErrorCount;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] pos;
        logic             dir;
        logic             homed;
        logic             err;
        logic [7:0]       cnt;
    } expect_t;

    expect_t expQ[$];
    expect_t monExp;
    logic    sampleReq = 1'b0;
    int      totalCount = 0;
    int      badCount = 0;

    quadrature_decoder #(
        .WIDTH      (WIDTH),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .A            (A),
        .B            (B),
        .I            (I),
        .DataBus      (DataBus),
        .LoadCPR      (LoadCPR),
        .LoadPosition (LoadPosition),
        .IndexMode    (IndexMode),
        .ArmIndex     (ArmIndex),
        .ClearError   (ClearError),
        .Position     (Position),
        .Direction    (Direction),
        .Homed        (Homed),
        .Error        (Error),
        .ErrorCount   (ErrorCount)
    );

    // Free-running 100 MHz system clock.
    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input int a, input int b, input int i, input int cycles);
        A = (a != 0);
        B = (b != 0);
        I = (i != 0);
        tick(cycles);
    endtask

    task automatic loadPosition(input logic [WIDTH-1:0] value);
        DataBus      = value;
        LoadPosition = 1'b1;
        tick(1);
        LoadPosition = 1'b0;
    endtask

    task automatic loadCpr(input logic [WIDTH-1:0] value);
        DataBus = value;
        LoadCPR = 1'b1;
        tick(1);
        LoadCPR = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] pos,
                               input int dir, input int homed, input int err, input int cnt);
        expect_t e;
        e.name  = name;
        e.pos   = pos;
        e.dir   = (dir != 0);
        e.homed = (homed != 0);
        e.err   = (err != 0);
        e.cnt   = 8'(cnt);
        expQ.push_back(e);
        sampleReq = 1'b1;
        tick(1);
        sampleReq = 1'b0;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s/%s: got %0h, expected %0h", name, field, actual, expected);
        end
    endtask

    // Monitor: on each sample request, pop the oldest expectation and compare.
    always @(negedge Clock) begin
        if (sampleReq) begin
            if (expQ.size() == 0) begin
                totalCount++;
                badCount++;
                $display("[TB] FAIL scoreboard: sample requested with empty queue");
            end else begin
                monExp = expQ.pop_front();
                compareField(monExp.name, "Position", Position, monExp.pos);
                compareField(monExp.name, "Direction", WIDTH'(Direction), WIDTH'(monExp.dir));
                compareField(monExp.name, "Homed", WIDTH'(Homed), WIDTH'(monExp.homed));
                compareField(monExp.name, "Error", WIDTH'(Error), WIDTH'(monExp.err));
                compareField(monExp.name, "ErrorCount", WIDTH'(ErrorCount), WIDTH'(monExp.cnt));
            end
        end
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        Reset_n      = 1'b0;
        A            = 1'b0;
        B            = 1'b0;
        I            = 1'b0;
        DataBus      = '0;
        LoadCPR      = 1'b0;
        LoadPosition = 1'b0;
        IndexMode    = 2'd0;
        ArmIndex     = 1'b0;
        ClearError   = 1'b0;
        tick(3);
        checkOutput("reset", 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        tick(12);
        checkOutput("idle", 0, 0, 0, 0, 0);

        // First edge: unchanged after 5 edges, stepped on the 6th
        A = 1'b1;
        tick(5);
        checkOutput("latency_before", 0, 0, 0, 0, 0);
        checkOutput("latency_step", 1, 1, 0, 0, 0);
        tick(PHASE - 7);
        applyStimulus(1, 1, 0, PHASE);
        applyStimulus(0, 1, 0, PHASE);
        applyStimulus(0, 0, 0, PHASE);
        for (int c = 1; c < 4; c++) begin
            applyStimulus(1, 0, 0, PHASE);
            applyStimulus(1, 1, 0, PHASE);
            applyStimulus(0, 1, 0, PHASE);
            applyStimulus(0, 0, 0, PHASE);
        end
        checkOutput("cw_16", 16, 1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, 0, PHASE);
            applyStimulus(1, 1, 0, PHASE);
            applyStimulus(1, 0, 0, PHASE);
            applyStimulus(0, 0, 0, PHASE);
        end
        checkOutput("ccw_back_0", 0, 0, 0, 0, 0);

        // CPR wrap
        loadCpr(100);
        checkOutput("loadcpr_keeps_pos", 0, 0, 0, 0, 0);
        loadPosition(99);
        checkOutput("load_99", 99, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("cpr_cw_wrap", 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("cpr_ccw_wrap", 99, 0, 0, 0, 0);
        loadPosition(150);
        checkOutput("load_150", 150, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("cpr_out_of_range", 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("cpr_ccw_again", 99, 0, 0, 0, 0);
        loadCpr(0);
        loadPosition(10);
        checkOutput("unbounded_restore", 10, 0, 0, 0, 0);

        // Glitch filter
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("glitch_rejected", 10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("stable_change", 11, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("stable_back", 10, 0, 0, 0, 0);

        // Illegal transitions
        applyStimulus(1, 1, 0, PHASE);
        checkOutput("illegal_first", 10, 0, 0, 1, 1);
        for (int n = 0; n < 299; n++) begin
            A = ~A;
            B = ~B;
            tick(5);
        end
        tick(PHASE);
        checkOutput("illegal_saturate", 10, 0, 0, 1, 255);
        ClearError = 1'b1;
        tick(1);
        ClearError = 1'b0;
        checkOutput("clear_error", 10, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, PHASE);
        checkOutput("illegal_again", 10, 0, 0, 1, 1);
        A = 1'b0;
        B = 1'b0;
        tick(5);
        ClearError = 1'b1;
        tick(1);
        ClearError = 1'b0;
        tick(4);
        checkOutput("clear_with_illegal", 10, 0, 0, 1, 1);

        // Index homing, mode 2 then mode 1 then mode 0
        loadPosition(37);
        IndexMode = 2'd2;
        checkOutput("index_armed", 37, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, PHASE);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("mode2_first_index", 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("step_after_home", 1, 1, 1, 1, 1);
        applyStimulus(1, 0, 1, PHASE);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("mode2_second_ignored", 1, 1, 1, 1, 1);
        ArmIndex = 1'b1;
        tick(1);
        ArmIndex = 1'b0;
        checkOutput("arm_clears_homed", 1, 1, 0, 1, 1);
        applyStimulus(1, 0, 1, PHASE);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("mode2_rehome", 0, 1, 1, 1, 1);
        IndexMode = 2'd1;
        applyStimulus(1, 1, 0, PHASE);
        checkOutput("mode1_step1", 1, 1, 1, 1, 1);
        applyStimulus(1, 1, 1, PHASE);
        applyStimulus(1, 1, 0, PHASE);
        checkOutput("mode1_zero1", 0, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, PHASE);
        checkOutput("mode1_step2", 1, 1, 1, 1, 1);
        applyStimulus(0, 1, 1, PHASE);
        applyStimulus(0, 1, 0, PHASE);
        checkOutput("mode1_zero2", 0, 1, 1, 1, 1);
        IndexMode = 2'd0;
        applyStimulus(0, 0, 0, PHASE);
        applyStimulus(0, 0, 1, PHASE);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("mode0_ignored", 1, 1, 1, 1, 1);
        applyStimulus(0, 1, 0, PHASE);
        checkOutput("ccw_before_priority", 0, 0, 1, 1, 1);

        // Load beats index zeroing and a CW step decoded in the same cycle
        IndexMode = 2'd1;
        A = 1'b0;
        B = 1'b0;
        I = 1'b1;
        tick(5);
        DataBus      = 500;
        LoadPosition = 1'b1;
        tick(1);
        LoadPosition = 1'b0;
        tick(4);
        checkOutput("load_beats_index_step", 500, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, PHASE);
        applyStimulus(1, 0, 0, PHASE);
        checkOutput("count_after_load", 501, 1, 1, 1, 1);

        // Mid-operation reset with A held high across release
        Reset_n = 1'b0;
        tick(2);
        checkOutput("mid_reset", 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        tick(20);
        checkOutput("a_high_across_release", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, PHASE);
        checkOutput("unbounded_negative_wrap", 32'hFFFF_FFFF, 0, 0, 0, 0);

        tick(2);
        if (expQ.size() != 0) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL scoreboard: %0d expectations never sampled", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
